// File: rtl/north_sel_pkg.sv
// north_sel_pkg: shared state type, select-width derivation and config decode for north_pad_selector.
package north_sel_pkg;
  typedef enum logic {IDLE, BLANK} state_t;
  localparam int unsigned SEL_W_MAX = 3;
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  // Words below 2*N fold onto the macro range; anything else selects macro 0.
  function automatic logic [7:0] decode(input logic [31:0] cfg, input int unsigned n);
    return (cfg < 2 * n) ? 8'(cfg % n) : 8'd0;
  endfunction
endpackage

// File: rtl/north_pad_selector_blank_timer.sv
// blank_timer: loadable down-counter that saturates at zero and flags done when empty.
module blank_timer #(
  parameter int GUARD = 2,
  localparam int CW = $clog2(GUARD) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          done
);
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (load) value <= load_value;
    else if (value != '0) value <= value - 1'b1;
  assign done = value == '0;
endmodule

// File: rtl/north_pad_selector.sv
// north_pad_selector: routes one of N macros to the north pads with break-before-make blanking.
// Optional NORTH_SEL_LOCK_EN adds a sel_lock input that freezes the selection while idle.
module north_pad_selector
  import north_sel_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 10,
  parameter int CFG_W = 4,
  parameter int GUARD = 2,
  localparam int SW = sel_width(N),
  localparam int CW = $clog2(GUARD) + 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef NORTH_SEL_LOCK_EN
  input  logic                sel_lock,
`endif
  input  logic                cfg_valid,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_ready,
  input  logic [N-1:0][W-1:0] north_o,
  input  logic [N-1:0][W-1:0] north_oe,
  output logic [W-1:0]        north_o_selected,
  output logic [W-1:0]        north_oe_selected,
  output logic [SW-1:0]       sel,
  output logic                busy
);
  state_t        state;
  logic [SW-1:0] pending, target;
  logic [CW-1:0] value;
  logic          lock, load, done, blank;
`ifdef NORTH_SEL_LOCK_EN
  assign lock = sel_lock;
`else
  assign lock = 1'b0;
`endif
  assign target    = SW'(decode(32'(cfg_data), N));
  assign cfg_ready = (state == IDLE) && !lock;
  assign load      = cfg_ready && cfg_valid && (target != sel);
  assign blank     = rst || (state == BLANK);
  // A nonzero count only exists inside BLANK, so this is the same as the state flag.
  assign busy      = (state == BLANK) || (value != '0);
  assign north_o_selected  = blank ? '0 : north_o[sel];
  assign north_oe_selected = blank ? '0 : north_oe[sel];
  blank_timer #(.GUARD(GUARD)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_value(CW'(GUARD - 1)), .value(value), .done(done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      pending <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        pending <= target;
        state   <= BLANK;
      end
    end else if (done) begin
      sel   <= pending;
      state <= IDLE;
    end
endmodule

// File: tb/tb_north_pad_selector.sv
// tb_north_pad_selector: directed and random stimulus against a cycle-count reference model.
module tb_north_pad_selector;
  localparam int N = 4, W = 10, CFG_W = 4, GUARD = 2;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_ready, busy;
  logic [CFG_W-1:0] cfg_data = '0;
  logic [N-1:0][W-1:0] north_o = '0, north_oe = '0;
  logic [W-1:0] north_o_selected, north_oe_selected;
  logic [1:0] sel;
  int vectors = 0, miscompares = 0;
  int m_sel = 0, m_pend = 0, m_blank = 0;
`ifdef NORTH_SEL_LOCK_EN
  logic sel_lock = 1'b0;
`endif
  always #5 clk = ~clk;
  north_pad_selector #(.N(N), .W(W), .CFG_W(CFG_W), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst),
`ifdef NORTH_SEL_LOCK_EN
    .sel_lock(sel_lock),
`endif
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .north_o(north_o), .north_oe(north_oe),
    .north_o_selected(north_o_selected), .north_oe_selected(north_oe_selected),
    .sel(sel), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive one cycle, compare against the model, then advance the model across the edge.
  task automatic step(input logic v, input logic [CFG_W-1:0] d, input logic r);
    int t;
    logic idle_pads;
    @(negedge clk);
    cfg_valid = v;
    cfg_data  = d;
    rst       = r;
    north_o   = 40'({$urandom(), $urandom()});
    north_oe  = 40'({$urandom(), $urandom()});
    #1;
    idle_pads = !r && (m_blank == 0);
    check("cfg_ready", 32'(cfg_ready), 32'(m_blank == 0));
    check("busy", 32'(busy), 32'(m_blank != 0));
    check("sel", 32'(sel), 32'(m_sel));
    check("north_o_selected", 32'(north_o_selected), idle_pads ? 32'(north_o[m_sel]) : 32'd0);
    check("north_oe_selected", 32'(north_oe_selected), idle_pads ? 32'(north_oe[m_sel]) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_sel = 0;
      m_blank = 0;
    end else if (m_blank > 0) begin
      m_blank--;
      if (m_blank == 0) m_sel = m_pend;
    end else if (v) begin
      t = (int'(d) < 2 * N) ? int'(d) % N : 0;
      if (t != m_sel) begin
        m_pend = t;
        m_blank = GUARD;
      end
    end
  endtask
  initial begin
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 3, 0);
    for (int i = 0; i < GUARD + 1; i++) step(0, 0, 0);
    step(1, 3, 0);
    step(1, 7, 0);
    step(0, 0, 0);
    step(1, 4, 0);
    for (int i = 0; i < GUARD + 1; i++) step(0, 0, 0);
    step(1, 4, 0);
    step(1, 2, 0);
    for (int i = 0; i < GUARD + 1; i++) step(0, 0, 0);
    step(1, 9, 0);
    for (int i = 0; i < GUARD + 1; i++) step(0, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < GUARD + 1; i++) step(1, 2, 0);
    for (int i = 0; i < GUARD + 1; i++) step(0, 0, 0);
    step(1, 3, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 40) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/north_pad_selector.md
# north_pad_selector

Parametrised successor to the two-macro north pad mux. It routes one of N macros' north output and output-enable buses to the shared north pads, selected by a configuration word. The selection changes only through a valid/ready handshake, with a break-before-make blanking window so two macros never drive the pads back to back. It sits between the macro array and the north pad ring, one instance per pad edge.

## Interface
- N, default 4: number of macros, legal range 2..8.
- W, default 10: pad bus width.
- CFG_W, default 4: configuration word width; requires 2**CFG_W >= 2*N.
- GUARD, default 2: blanking cycles on a selection change, minimum 1.

- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new configuration offered.
- cfg_data  in  CFG_W  configuration word.
- cfg_ready  out  1  block can accept a configuration.
- north_o  in  W x N  per-macro north outputs, index 0..N-1.
- north_oe  in  W x N  per-macro north output enables.
- north_o_selected  out  W  pad output bus.
- north_oe_selected  out  W  pad output-enable bus.
- sel  out  $clog2(N)  currently committed macro index.
- busy  out  1  blanking in progress.

## Operation
- Config decode: for cfg_data < 2*N, target = cfg_data mod N; all other values give target 0. With N=2 this reproduces the legacy 0/1/0/1 map.
- The FSM has two states: IDLE and BLANK.
- IDLE
  - cfg_ready=1, busy=0.
  - Pads pass through combinationally: north_o_selected=north_o[sel], north_oe_selected=north_oe[sel].
  - On a handshake (cfg_valid & cfg_ready) where target == sel: the request is accepted, the state stays IDLE, and the pads see no disturbance.
  - On a handshake where target != sel: the block latches pending=target, loads the counter with GUARD-1 and moves to BLANK.
- BLANK
  - cfg_ready=0, busy=1.
  - Both pad buses are forced to all zeros.
  - The counter decrements each cycle. When it reaches 0, the next edge sets sel<=pending and returns to IDLE.
- cfg_valid while cfg_ready=0 is held off. The offer is not lost; the source keeps it asserted.
- Reset values: state IDLE, sel=0, pending=0, counter=0, busy=0, cfg_ready=1.
- Reset asserted mid-BLANK discards pending. The next cycle is IDLE with sel=0.
- While rst is high, both pad buses are forced to zero combinationally.

## Timing
- Handshake at edge k with target != sel:
  - Cycles k+1 .. k+GUARD are BLANK, with pads at zero.
  - The new sel is visible from cycle k+GUARD+1, and pads show the new macro in that cycle.
  - cfg_ready is high again in cycle k+GUARD+1.
- Handshake with target == sel has zero latency and no blank cycles.
- Macro-to-pad data path is combinational with zero latency. Only control (sel, state) is registered.
- Maximum accepted configuration rate is one per GUARD+1 cycles on changes, and one per cycle on no-op requests.

## Configuration
- NORTH_SEL_LOCK_EN defined:
  - Adds input port sel_lock (1 bit).
  - While sel_lock=1 in IDLE, cfg_ready=0 and the current selection is frozen.
  - Asserting sel_lock during BLANK does not abort the switch. It takes effect once IDLE is reached.
- NORTH_SEL_LOCK_EN undefined: the port is absent and the block behaves as if sel_lock=0.

## Structure
- Package north_sel_pkg holds:
  - the state enum {IDLE, BLANK};
  - the sel width localparam derivation;
  - the config-decode function (cfg_data, N) -> target.
- One sub-module, blank_timer: a loadable down-counter sized $clog2(GUARD)+1, with load, value and done (count==0) outputs.

## Test plan
- Reset, N=4: pads equal north_o[0]/north_oe[0], sel=0, cfg_ready=1, busy=0.
- cfg_data=3, GUARD=2: exactly 2 cycles of zero pads and busy=1, then sel=3 and pads equal macro 3.
- cfg_data=4 at N=4 (maps to 0) while sel=0: accepted with no blank cycle and no pad glitch.
- cfg_data=9 at N=4 (out of range): target 0 and switches from sel=2 to 0 with blanking.
- cfg_valid held through BLANK with a second request: it waits, is accepted in the first IDLE cycle, and BLANK repeats.
- rst pulsed in the middle of BLANK toward macro 3: IDLE with sel=0 next cycle. With NORTH_SEL_LOCK_EN and sel_lock=1: cfg_ready=0 and sel is unchanged.
